// File: rtl/output_buf_ctrl.sv
// Output buffer controller: two PIM captures (group 1, group 2), then a valid/ready hand-off.
// Optional macro OBUF_TIMEOUT_EN adds a PIM response timeout counter and an ERR state.
module output_buf_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic pim_req_o,
    output logic pim_sel_o,
    input  logic pim_valid_i,
    output logic buf_write_en_1_o,
    output logic buf_write_en_2_o,
    output logic buf_read_en_o,
    output logic out_valid_o,
    input  logic out_ready_i,
    output logic done_o,
    output logic err_o
);

    // The timeout must fit the 16-bit counter and leave room for a non-zero wait.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

`ifdef OBUF_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_WAIT2, S_SEND, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WAIT1, S_WAIT2, S_SEND} state_t;
`endif

    state_t r_state;
    state_t w_next;
    logic   w_timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

`ifdef OBUF_TIMEOUT_EN
    logic [15:0] r_cnt;

    // Counter restarts on every state change, so it is zero on entry to each WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                          r_cnt <= '0;
        else if (w_next != r_state)                         r_cnt <= '0;
        else if (r_state == S_WAIT1 || r_state == S_WAIT2)  r_cnt <= r_cnt + 16'd1;
    end

    assign w_timeout = (r_cnt == 16'(TIMEOUT_CYCLES - 1)) && !pim_valid_i;
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_next           = r_state;
        busy_o           = 1'b1;
        pim_req_o        = 1'b0;
        pim_sel_o        = 1'b0;
        buf_write_en_1_o = 1'b0;
        buf_write_en_2_o = 1'b0;
        buf_read_en_o    = 1'b0;
        out_valid_o      = 1'b0;
        done_o           = 1'b0;
        err_o            = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) w_next = S_WAIT1;
            end
            S_WAIT1: begin
                pim_req_o        = 1'b1;
                buf_write_en_1_o = pim_valid_i;
                if (pim_valid_i) w_next = S_WAIT2;
`ifdef OBUF_TIMEOUT_EN
                else if (w_timeout) w_next = S_ERR;
`endif
            end
            S_WAIT2: begin
                pim_req_o        = 1'b1;
                pim_sel_o        = 1'b1;
                buf_write_en_2_o = pim_valid_i;
                if (pim_valid_i) w_next = S_SEND;
`ifdef OBUF_TIMEOUT_EN
                else if (w_timeout) w_next = S_ERR;
`endif
            end
            S_SEND: begin
                buf_read_en_o = 1'b1;
                out_valid_o   = 1'b1;
                done_o        = out_ready_i;
                if (out_ready_i) w_next = S_IDLE;
            end
`ifdef OBUF_TIMEOUT_EN
            S_ERR: begin
                err_o = 1'b1;
                if (start_i) w_next = S_WAIT1;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_output_buf_ctrl.sv
// Randomized + directed bench for output_buf_ctrl against a transaction-level model
// (active flag, groups-captured count, cycles-waited count, error flag).
module tb_output_buf_ctrl;

    localparam int TB_T = 8;

    logic clk_i = 1'b0;
    logic rst_i, start_i, pim_valid_i, out_ready_i;
    logic busy_o, pim_req_o, pim_sel_o, buf_write_en_1_o, buf_write_en_2_o;
    logic buf_read_en_o, out_valid_o, done_o, err_o;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state.
    bit m_act;
    int m_cap;
    int m_w;
    bit m_err;

    output_buf_ctrl #(.TIMEOUT_CYCLES(TB_T)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
        .pim_req_o(pim_req_o), .pim_sel_o(pim_sel_o), .pim_valid_i(pim_valid_i),
        .buf_write_en_1_o(buf_write_en_1_o), .buf_write_en_2_o(buf_write_en_2_o),
        .buf_read_en_o(buf_read_en_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_cap = 0; m_w = 0; m_err = 0;
    endtask

    task automatic check_outs(input string ph);
        bit send;
        send = m_act && m_cap == 2;
        chk({ph, ":busy"},  16'(busy_o),           16'(m_act || m_err));
        chk({ph, ":req"},   16'(pim_req_o),        16'(m_act && m_cap < 2));
        chk({ph, ":sel"},   16'(pim_sel_o),        16'(m_act && m_cap == 1));
        chk({ph, ":we1"},   16'(buf_write_en_1_o), 16'(m_act && m_cap == 0 && pim_valid_i));
        chk({ph, ":we2"},   16'(buf_write_en_2_o), 16'(m_act && m_cap == 1 && pim_valid_i));
        chk({ph, ":rd"},    16'(buf_read_en_o),    16'(send));
        chk({ph, ":ovld"},  16'(out_valid_o),      16'(send));
        chk({ph, ":done"},  16'(done_o),           16'(send && out_ready_i));
        chk({ph, ":err"},   16'(err_o),            16'(m_err));
    endtask

    task automatic model_step();
        if (m_err) begin
            if (start_i) begin m_err = 0; m_act = 1; m_cap = 0; m_w = 0; end
        end else if (!m_act) begin
            if (start_i) begin m_act = 1; m_cap = 0; m_w = 0; end
        end else if (m_cap == 2) begin
            if (out_ready_i) m_act = 0;
        end else if (pim_valid_i) begin
            m_cap++; m_w = 0;
        end else begin
            m_w++;
`ifdef OBUF_TIMEOUT_EN
            if (m_w == TB_T) begin m_act = 0; m_err = 1; end
`endif
        end
    endtask

    task automatic cycle(input string ph, input bit s, input bit v, input bit r);
        @(negedge clk_i);
        start_i = s; pim_valid_i = v; out_ready_i = r;
        #1 check_outs(ph);
        @(posedge clk_i);
        if (!rst_i) model_step();
    endtask

    initial begin
        rst_i = 1; start_i = 0; pim_valid_i = 0; out_ready_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        // Inputs that would otherwise fire must be masked under reset.
        start_i = 1; pim_valid_i = 1; out_ready_i = 1;
        #1 check_outs("rst");
        @(negedge clk_i);
        rst_i = 0; start_i = 0; pim_valid_i = 0; out_ready_i = 0;

        // Nominal minimum latency.
        cycle("nom", 1, 0, 1);
        cycle("nom", 0, 1, 1);
        cycle("nom", 0, 1, 1);
        cycle("nom", 0, 0, 1);
        cycle("nom", 0, 0, 1);
        chk("nom:idle", 16'(busy_o), 16'd0);

        // Stalls on both groups and on the consumer.
        cycle("stl", 1, 0, 0);
        repeat (5) cycle("stl", 0, 0, 0);
        cycle("stl", 0, 1, 0);
        repeat (5) cycle("stl", 0, 0, 0);
        cycle("stl", 0, 1, 0);
        repeat (4) cycle("stl", 0, 0, 0);
        cycle("stl", 0, 0, 1);
        cycle("stl", 0, 0, 0);

        // Ignored start/valid pulses.
        cycle("ign", 0, 1, 1);
        cycle("ign", 1, 0, 0);
        cycle("ign", 0, 1, 0);
        cycle("ign", 1, 0, 0);
        cycle("ign", 0, 1, 0);
        cycle("ign", 1, 0, 1);
        cycle("ign", 0, 1, 0);
        cycle("ign", 0, 0, 0);

        // Asynchronous reset in WAIT2, mid-cycle.
        cycle("ar", 1, 0, 0);
        cycle("ar", 0, 1, 0);
        @(negedge clk_i);
        start_i = 0; pim_valid_i = 1; out_ready_i = 0;
        #1 check_outs("ar_pre");
        rst_i = 1;
        #1 model_reset();
        check_outs("ar_in");
        @(negedge clk_i);
        rst_i = 0;
        repeat (3) cycle("ar_post", 0, 1, 0);

`ifdef OBUF_TIMEOUT_EN
        // Timeout to ERR, then recovery via start.
        cycle("to", 1, 0, 0);
        repeat (TB_T) cycle("to", 0, 0, 0);
        cycle("to_err", 0, 0, 0);
        chk("to:err_hi", 16'(err_o), 16'd1);
        cycle("to_rst", 1, 0, 0);
        cycle("to_w1", 0, 0, 0);
        chk("to:err_clr", 16'(err_o), 16'd0);
        // Valid on the terminal-count cycle wins.
        repeat (TB_T - 2) cycle("tb", 0, 0, 0);
        cycle("tb_term", 0, 1, 0);
        cycle("tb_w2", 0, 0, 0);
        chk("tb:sel", 16'(pim_sel_o), 16'd1);
        repeat (TB_T - 2) cycle("tb", 0, 0, 0);
        cycle("tb_term2", 0, 1, 0);
        cycle("tb_send", 0, 0, 1);
        cycle("tb_end", 0, 0, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd", ($urandom_range(3) == 0), ($urandom_range(2) == 0),
                  ($urandom_range(2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/output_buf_ctrl.md
OUTPUT_BUF_CTRL -- requirements
Module: output_buf_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of cycles a PIM response wait may last before a timeout (used only with OBUF_TIMEOUT_EN).
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1 bit: request to run one two-group capture sequence.
REQ-005 The block SHALL have port busy_o, output, 1 bit: high whenever state is not IDLE.
REQ-006 The block SHALL have port pim_req_o, output, 1 bit: level read request to the eFlash PIM.
REQ-007 The block SHALL have port pim_sel_o, output, 1 bit: mapping group selected for the request (0 = group 1, 1 = group 2).
REQ-008 The block SHALL have port pim_valid_i, input, 1 bit: the PIM 32-bit output is valid this cycle.
REQ-009 The block SHALL have ports buf_write_en_1_o and buf_write_en_2_o, output, 1 bit each: write strobes to the 4x8b output buffer bank 1 and bank 2.
REQ-010 The block SHALL have port buf_read_en_o, output, 1 bit: buffer read enable.
REQ-011 The block SHALL have ports out_valid_o (output, 1 bit) and out_ready_i (input, 1 bit): valid/ready handshake for buffer contents to the consumer.
REQ-012 The block SHALL have port done_o, output, 1 bit: high only in the cycle the output handshake completes.
REQ-013 The block SHALL have port err_o, output, 1 bit: PIM response timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT1, WAIT2, SEND, and ERR; ERR exists only with OBUF_TIMEOUT_EN.
REQ-015 In IDLE, start_i=1 SHALL move the FSM to WAIT1 at the next edge; start_i SHALL be ignored in WAIT1, WAIT2 and SEND.
REQ-016 In WAIT1, pim_req_o SHALL be 1 and pim_sel_o SHALL be 0; in WAIT2, pim_req_o SHALL be 1 and pim_sel_o SHALL be 1; in all other states both SHALL be 0.
REQ-017 buf_write_en_1_o SHALL equal (state==WAIT1 and pim_valid_i), combinationally, so the buffer captures the same-cycle PIM data; that cycle's edge SHALL move the FSM to WAIT2.
REQ-018 buf_write_en_2_o SHALL equal (state==WAIT2 and pim_valid_i), combinationally; that cycle's edge SHALL move the FSM to SEND.
REQ-019 The two write enables SHALL never be high in the same cycle; pim_valid_i outside WAIT1/WAIT2 SHALL be ignored.
REQ-020 In SEND, buf_read_en_o and out_valid_o SHALL both be 1; out_valid_o SHALL stay high until out_ready_i=1.
REQ-021 In SEND with out_ready_i=1, done_o SHALL be 1 that cycle and the FSM SHALL return to IDLE; a start_i in that same cycle SHALL be ignored.
REQ-022 Minimum latency SHALL be: start_i at cycle 0, pim_valid_i at cycles 1 and 2, out_ready_i high at cycle 3, giving done_o at cycle 3 and busy_o low at cycle 4.

Reset
REQ-023 While rst_i=1, the state SHALL be IDLE, the timeout counter SHALL be 0, and every output SHALL be 0, regardless of the clock.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence with no further write strobe; the buffer contents are not cleared by this block.

Configuration
REQ-025 With macro OBUF_TIMEOUT_EN defined, an 8- to 16-bit counter SHALL clear on entry to WAIT1 or WAIT2 and increment each cycle the FSM stays there.
REQ-026 With OBUF_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without pim_valid_i, the FSM SHALL move to ERR with no write strobe.
REQ-027 With OBUF_TIMEOUT_EN defined, err_o SHALL be 1 in ERR; start_i in ERR SHALL clear err_o and move the FSM to WAIT1.
REQ-028 With OBUF_TIMEOUT_EN defined, pim_valid_i in the same cycle as the terminal count SHALL take priority, giving a normal capture.
REQ-029 Without OBUF_TIMEOUT_EN, the block SHALL have no counter and no ERR state, err_o SHALL be tied to 0, and WAIT states SHALL wait indefinitely.

Verification
REQ-030 Nominal: start_i at cycle 0, pim_valid_i at cycles 1 and 2, out_ready_i=1 -> write_en_1 at cycle 1, write_en_2 at cycle 2, out_valid_o/buf_read_en_o/done_o at cycle 3, busy_o=0 at cycle 4.
REQ-031 Stalls: pim_valid_i delayed 5 cycles per group, out_ready_i low 4 cycles -> pim_req_o held with pim_sel_o 0 then 1, exactly one strobe per group, out_valid_o held 5 cycles, one done_o pulse.
REQ-032 Ignored inputs: start_i pulsed in WAIT2 and in the SEND completion cycle, pim_valid_i pulsed in IDLE -> no extra sequence and no strobe.
REQ-033 Reset: rst_i asserted asynchronously in WAIT2 -> all outputs 0 immediately; after release, state is IDLE and no write_en_2 occurs.
REQ-034 Timeout (OBUF_TIMEOUT_EN, TIMEOUT_CYCLES=8): no pim_valid_i after start_i -> ERR entered after 8 WAIT1 cycles with err_o=1; a later start_i clears err_o and re-enters WAIT1.
REQ-035 Timeout boundary (OBUF_TIMEOUT_EN, TIMEOUT_CYCLES=8): pim_valid_i on the terminal-count cycle -> write_en_1 pulses, FSM enters WAIT2, err_o stays 0.
